// File: rtl/yarp_dmem_arbiter.sv
// Shares the single-port data memory between the core load/store path and the AES fetch engine.
// One transaction in flight; round-robin on ties; sticky error flag on read timeout.
module yarp_dmem_arbiter #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        core_req_i,
  input  logic [31:0] core_addr_i,
  input  logic        core_wr_i,
  input  logic [1:0]  core_byte_i,
  input  logic [31:0] core_wdata_i,
  output logic        core_gnt_o,
  output logic        core_rsp_o,
  input  logic        aes_req_i,
  input  logic [31:0] aes_addr_i,
  input  logic        aes_wr_i,
  input  logic [1:0]  aes_byte_i,
  input  logic [31:0] aes_wdata_i,
  output logic        aes_gnt_o,
  output logic        aes_rsp_o,
  output logic [31:0] rsp_rdata_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_wr_o,
  output logic [1:0]  mem_byte_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        err_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUS  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       state;
  logic             owner_aes;
  logic             last_aes;
  logic [CNT_W-1:0] cnt;

  logic any_req;
  logic pick_aes;
  logic capture;
  logic wr_done;
  logic rd_done;
  logic rd_timeout;
  logic done;

  // Handshake outputs are combinational and held low while reset is asserted,
  // so a reset in mid-transaction never leaks a grant or completion pulse.
  always_comb begin
    any_req    = core_req_i | aes_req_i;
    pick_aes   = aes_req_i & (~core_req_i | ~last_aes);
    capture    = reset_n & (state == IDLE) & any_req;
    wr_done    = reset_n & (state == BUS) & mem_gnt_i & mem_wr_o;
    rd_done    = reset_n & (state == RESP) & mem_rvalid_i;
    rd_timeout = reset_n & (state == RESP) & ~mem_rvalid_i & (cnt == CNT_LAST);
    done       = wr_done | rd_done | rd_timeout;
  end

  assign core_gnt_o  = capture & ~pick_aes;
  assign aes_gnt_o   = capture & pick_aes;
  assign core_rsp_o  = done & ~owner_aes;
  assign aes_rsp_o   = done & owner_aes;
  assign rsp_rdata_o = rd_done ? mem_rdata_i : 32'h0;
  assign mem_req_o   = reset_n & (state == BUS);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      owner_aes   <= 1'b0;
      last_aes    <= 1'b1;
      cnt         <= '0;
      err_o       <= 1'b0;
      mem_addr_o  <= 32'h0;
      mem_wr_o    <= 1'b0;
      mem_byte_o  <= 2'b00;
      mem_wdata_o <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner_aes   <= pick_aes;
            last_aes    <= pick_aes;
            mem_addr_o  <= pick_aes ? aes_addr_i  : core_addr_i;
            mem_wr_o    <= pick_aes ? aes_wr_i    : core_wr_i;
            mem_byte_o  <= pick_aes ? aes_byte_i  : core_byte_i;
            mem_wdata_o <= pick_aes ? aes_wdata_i : core_wdata_i;
            state       <= BUS;
          end
        end
        BUS: begin
          if (mem_gnt_i) begin
            cnt   <= '0;
            state <= mem_wr_o ? IDLE : RESP;
          end
        end
        RESP: begin
          // rvalid takes priority over the timeout in the same cycle.
          if (rd_done || rd_timeout) begin
            state <= IDLE;
            if (rd_timeout) err_o <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_yarp_dmem_arbiter.sv
// Bench for yarp_dmem_arbiter: directed scenarios, then random traffic against a scoreboard.
module tb_yarp_dmem_arbiter;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        core_req_i = 1'b0, core_wr_i = 1'b0;
  logic [31:0] core_addr_i = '0, core_wdata_i = '0;
  logic [1:0]  core_byte_i = '0;
  logic        core_gnt_o, core_rsp_o;
  logic        aes_req_i = 1'b0, aes_wr_i = 1'b0;
  logic [31:0] aes_addr_i = '0, aes_wdata_i = '0;
  logic [1:0]  aes_byte_i = '0;
  logic        aes_gnt_o, aes_rsp_o;
  logic [31:0] rsp_rdata_o;
  logic        mem_req_o, mem_wr_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [1:0]  mem_byte_o;
  logic        mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        err_o;

  yarp_dmem_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .core_req_i(core_req_i), .core_addr_i(core_addr_i), .core_wr_i(core_wr_i),
    .core_byte_i(core_byte_i), .core_wdata_i(core_wdata_i),
    .core_gnt_o(core_gnt_o), .core_rsp_o(core_rsp_o),
    .aes_req_i(aes_req_i), .aes_addr_i(aes_addr_i), .aes_wr_i(aes_wr_i),
    .aes_byte_i(aes_byte_i), .aes_wdata_i(aes_wdata_i),
    .aes_gnt_o(aes_gnt_o), .aes_rsp_o(aes_rsp_o),
    .rsp_rdata_o(rsp_rdata_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_wr_o(mem_wr_o),
    .mem_byte_o(mem_byte_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { bit aes; logic [31:0] addr; bit wr; logic [1:0] sz; logic [31:0] wdata; } txn_t;
  typedef struct { int c; bit aes; logic [31:0] data; bit to; } rsp_t;

  txn_t exp_bus[$];
  rsp_t exp_rsp[$];
  int   n_pass = 0;
  int   n_tot = 0;
  bit   run = 1'b0;
  bit   m_idle, m_last_aes, m_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic clr();
    core_req_i = 0; aes_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
  endtask

  task automatic drive(input bit a, input bit req, input logic [31:0] ad, input bit wr,
                       input logic [1:0] sz, input logic [31:0] wd);
    if (a) begin
      aes_req_i = req; aes_addr_i = ad; aes_wr_i = wr; aes_byte_i = sz; aes_wdata_i = wd;
    end else begin
      core_req_i = req; core_addr_i = ad; core_wr_i = wr; core_byte_i = sz; core_wdata_i = wd;
    end
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, "_ctl"}, 32'({core_gnt_o, core_rsp_o, aes_gnt_o, aes_rsp_o, mem_req_o,
                           mem_wr_o, mem_byte_o, err_o}), 32'h0);
    chk({nm, "_dat"}, mem_addr_o | mem_wdata_o | rsp_rdata_o, 32'h0);
  endtask

  task automatic do_reset();
    reset_n = 0; clr();
    nxt();
    @(negedge clk); chk_quiet("reset");
    nxt();
    reset_n = 1;
  endtask

  // Core or AES requester: random gaps and fields, holds req until its grant.
  task automatic drv(input bit a, input int n);
    int gap, w;
    bit g;
    for (int k = 0; k < n; k++) begin
      gap = $urandom_range(0, 3);
      if (gap != 0) begin
        drive(a, 0, '0, 0, 2'b00, '0);
        repeat (gap) nxt();
      end
      drive(a, 1, $urandom, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), $urandom);
      g = 0;
      for (w = 0; w < 300 && !g; w++) begin
        @(negedge clk);
        g = a ? aes_gnt_o : core_gnt_o;
      end
      chk("rnd_gnt_wait", 32'(g), 32'h1);
      nxt();
      if (!g) break;
    end
    drive(a, 0, '0, 0, 2'b00, '0);
  endtask

  // Memory side: random grant delay, random read latency (including timeouts and
  // late rvalid), spurious rvalid outside the response window.
  task automatic responder();
    int g, d;
    txn_t t;
    logic [31:0] data;
    while (run) begin
      nxt();
      mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
      if (!mem_req_o) begin
        if ($urandom_range(0, 4) == 0) begin mem_rvalid_i = 1; mem_rdata_i = $urandom; end
        continue;
      end
      g = $urandom_range(0, 3);
      for (int j = 0; j < g; j++) begin
        mem_rvalid_i = 1'($urandom_range(0, 1)); mem_rdata_i = $urandom;
        nxt();
      end
      mem_rvalid_i = 0; mem_rdata_i = '0; mem_gnt_i = 1;
      if (exp_bus.size() == 0) continue;
      t = exp_bus[0];
      if (t.wr) begin
        exp_rsp.push_back('{c: cyc, aes: t.aes, data: 32'h0, to: 1'b0});
      end else begin
        d = $urandom_range(0, TO + 1);
        data = $urandom;
        if (d < TO) exp_rsp.push_back('{c: cyc + 1 + d, aes: t.aes, data: data, to: 1'b0});
        else        exp_rsp.push_back('{c: cyc + TO, aes: t.aes, data: 32'h0, to: 1'b1});
        nxt();
        mem_gnt_i = 0;
        repeat (d) nxt();
        mem_rvalid_i = 1; mem_rdata_i = data;
      end
    end
    clr();
  endtask

  // Scoreboard: predicts grants from the arbitration rule, checks the latched
  // memory fields against the granted request, and pops expected completions.
  task automatic monitor();
    bit ea;
    txn_t t;
    rsp_t r;
    m_idle = 1; m_last_aes = 1; m_err = 0;
    while (run) begin
      @(negedge clk);
      chk("rnd_err", 32'(err_o), 32'(m_err));
      if (m_idle && (core_req_i || aes_req_i)) begin
        ea = aes_req_i && (!core_req_i || !m_last_aes);
        chk("rnd_gnt", 32'({core_gnt_o, aes_gnt_o}), 32'({!ea, ea}));
        t.aes   = ea;
        t.addr  = ea ? aes_addr_i  : core_addr_i;
        t.wr    = ea ? aes_wr_i    : core_wr_i;
        t.sz    = ea ? aes_byte_i  : core_byte_i;
        t.wdata = ea ? aes_wdata_i : core_wdata_i;
        exp_bus.push_back(t);
        m_last_aes = ea; m_idle = 0;
      end else begin
        chk("rnd_nognt", 32'({core_gnt_o, aes_gnt_o}), 32'h0);
      end
      if (mem_req_o) begin
        if (exp_bus.size() == 0) chk("rnd_bus_unexpected", 32'(mem_req_o), 32'h0);
        else begin
          t = exp_bus[0];
          chk("rnd_addr", mem_addr_o, t.addr);
          chk("rnd_ctl", 32'({mem_wr_o, mem_byte_o}), 32'({t.wr, t.sz}));
          chk("rnd_wdata", mem_wdata_o, t.wdata);
          if (mem_gnt_i) void'(exp_bus.pop_front());
        end
      end
      while (exp_rsp.size() > 0 && exp_rsp[0].c < cyc) begin
        chk("rnd_rsp_missed", 32'(exp_rsp[0].c), 32'(cyc));
        void'(exp_rsp.pop_front());
        m_idle = 1;
      end
      if (exp_rsp.size() > 0 && exp_rsp[0].c == cyc) begin
        r = exp_rsp.pop_front();
        chk("rnd_rsp", 32'({core_rsp_o, aes_rsp_o}), 32'({!r.aes, r.aes}));
        chk("rnd_rdata", rsp_rdata_o, r.data);
        if (r.to) m_err = 1;
        m_idle = 1;
      end else begin
        chk("rnd_quiet", 32'({core_rsp_o, aes_rsp_o}) | rsp_rdata_o, 32'h0);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got time %0t, expected completion", $time);
    $fatal(1);
  end

  initial begin
    logic [1:0] ex;
    do_reset();

    // Single core load.
    drive(0, 1, 32'h100, 0, 2'b10, 32'h0);
    @(negedge clk); chk("d1_gnt", 32'({core_gnt_o, aes_gnt_o}), 32'h2);
    nxt(); core_req_i = 0; mem_gnt_i = 1;
    @(negedge clk);
    chk("d1_req", 32'({mem_req_o, mem_wr_o}), 32'h2);
    chk("d1_addr", mem_addr_o, 32'h100);
    chk("d1_norsp", 32'({core_rsp_o, aes_rsp_o}), 32'h0);
    nxt(); mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hCAFEF00D;
    @(negedge clk);
    chk("d1_rsp", 32'({core_rsp_o, aes_rsp_o}), 32'h2);
    chk("d1_rdata", rsp_rdata_o, 32'hCAFEF00D);
    nxt(); clr();
    @(negedge clk);
    chk("d1_after", 32'({core_rsp_o, aes_rsp_o, mem_req_o}), 32'h0);
    chk("d1_rdata0", rsp_rdata_o, 32'h0);

    // Both requesting from reset: strict alternation starting with the core.
    do_reset();
    drive(0, 1, 32'h10, 1, 2'b10, 32'h1);
    drive(1, 1, 32'h20, 1, 2'b10, 32'h2);
    mem_gnt_i = 1;
    for (int i = 0; i < 6; i++) begin
      ex = (i % 2 == 1) ? 2'b01 : 2'b10;
      @(negedge clk); chk("d2_gnt", 32'({core_gnt_o, aes_gnt_o}), 32'(ex));
      nxt();
      @(negedge clk);
      chk("d2_addr", mem_addr_o, (i % 2 == 1) ? 32'h20 : 32'h10);
      chk("d2_rsp", 32'({core_rsp_o, aes_rsp_o}), 32'(ex));
      nxt();
    end
    clr();

    // AES word store with the memory grant held off 4 cycles; spurious rvalid in BUS and IDLE.
    drive(1, 1, 32'h2000, 1, 2'b10, 32'h12345678);
    @(negedge clk); chk("d3_gnt", 32'({core_gnt_o, aes_gnt_o}), 32'h1);
    nxt(); aes_req_i = 0;
    for (int j = 0; j < 5; j++) begin
      mem_gnt_i = (j == 4); mem_rvalid_i = (j < 4); mem_rdata_i = 32'hDEAD0000 + 32'(j);
      @(negedge clk);
      chk("d3_bus", 32'({mem_req_o, mem_wr_o, mem_byte_o}), 32'hE);
      chk("d3_addr", mem_addr_o, 32'h2000);
      chk("d3_wdata", mem_wdata_o, 32'h12345678);
      chk("d3_rsp", 32'({core_rsp_o, aes_rsp_o}), (j == 4) ? 32'h1 : 32'h0);
      chk("d3_rdata", rsp_rdata_o, 32'h0);
      nxt();
    end
    mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hBEEF;
    @(negedge clk);
    chk("d3_idle_rvalid", 32'({core_rsp_o, aes_rsp_o, mem_req_o}), 32'h0);
    chk("d3_idle_rdata", rsp_rdata_o, 32'h0);
    nxt(); clr();

    // Read timeout, then rvalid on the last allowed cycle after a fresh reset.
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) do_reset();
      drive(0, 1, 32'h300, 0, 2'b10, 32'h0);
      @(negedge clk); chk("d4_gnt", 32'({core_gnt_o, aes_gnt_o}), 32'h2);
      nxt(); core_req_i = 0; mem_gnt_i = 1;
      nxt(); mem_gnt_i = 0;
      for (int j = 0; j < TO; j++) begin
        mem_rvalid_i = (pass == 1 && j == TO - 1); mem_rdata_i = 32'hA5A50001;
        @(negedge clk);
        chk("d4_rsp", 32'({core_rsp_o, aes_rsp_o}), (j == TO - 1) ? 32'h2 : 32'h0);
        chk("d4_noreq", 32'(mem_req_o), 32'h0);
        if (j == TO - 1) chk("d4_rdata", rsp_rdata_o, (pass == 1) ? 32'hA5A50001 : 32'h0);
        nxt();
      end
      clr();
      for (int j = 0; j < 3; j++) begin
        @(negedge clk);
        chk("d4_err", 32'(err_o), (pass == 0) ? 32'h1 : 32'h0);
        chk("d4_quiet", 32'({core_rsp_o, aes_rsp_o}), 32'h0);
        nxt();
      end
    end

    // Reset while waiting for read data; pending requests resume with the core winning.
    drive(0, 1, 32'h400, 0, 2'b01, 32'h0);
    nxt(); core_req_i = 0; mem_gnt_i = 1;
    nxt(); mem_gnt_i = 0;
    reset_n = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h1111;
    drive(0, 1, 32'h44, 1, 2'b10, 32'h5);
    drive(1, 1, 32'h88, 1, 2'b10, 32'h6);
    @(negedge clk);
    chk("d5_rst_ctl", 32'({core_gnt_o, core_rsp_o, aes_gnt_o, aes_rsp_o, mem_req_o}), 32'h0);
    chk("d5_rst_rdata", rsp_rdata_o, 32'h0);
    nxt(); mem_rvalid_i = 0;
    @(negedge clk);
    chk("d5_after_ctl", 32'({core_gnt_o, core_rsp_o, aes_gnt_o, aes_rsp_o, mem_req_o,
                             mem_wr_o, mem_byte_o, err_o}), 32'h0);
    chk("d5_after_dat", mem_addr_o | mem_wdata_o | rsp_rdata_o, 32'h0);
    nxt(); reset_n = 1;
    @(negedge clk); chk("d5_gnt_core", 32'({core_gnt_o, aes_gnt_o}), 32'h2);
    nxt(); core_req_i = 0; mem_gnt_i = 1;
    @(negedge clk); chk("d5_rsp_core", 32'({core_rsp_o, aes_rsp_o}), 32'h2);
    nxt();
    @(negedge clk); chk("d5_gnt_aes", 32'({core_gnt_o, aes_gnt_o}), 32'h1);
    nxt(); aes_req_i = 0;
    @(negedge clk); chk("d5_rsp_aes", 32'({core_rsp_o, aes_rsp_o}), 32'h1);
    nxt(); clr();

    // Random traffic against the scoreboard.
    do_reset();
    run = 1;
    fork
      begin
        fork
          drv(0, 40);
          drv(1, 40);
        join
        repeat (TO + 20) nxt();
        run = 0;
      end
      responder();
      monitor();
    join
    chk("rnd_drain", 32'(exp_bus.size() + exp_rsp.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
